// File: rtl/ram1_ctrl_pkg.sv
// Shared definitions for the ram1 data-memory controller: state encodings,
// bus widths and enable levels used by the controller and its byte-merge helper.
package ram1_ctrl_pkg;

    localparam int DataBus     = 32;
    localparam int DataAddrBus = 32;

    localparam logic RamChipEnable  = 1'b1;
    localparam logic RamChipDisable = 1'b0;
    localparam logic ReadEnable     = 1'b1;
    localparam logic ReadDisable    = 1'b0;
    localparam logic WriteEnable    = 1'b1;
    localparam logic WriteDisable   = 1'b0;

    localparam logic [DataBus-1:0] ZeroWord = 32'h0000_0000;
    localparam logic [3:0]         SelAll   = 4'b1111;
    localparam logic [3:0]         SelNone  = 4'b0000;

    typedef enum logic [2:0] {
        RamCtrlIdle   = 3'd0,
        RamCtrlRd     = 3'd1,
        RamCtrlMerge  = 3'd2,
        RamCtrlWr     = 3'd3,
        RamCtrlWrHold = 3'd4,
        RamCtrlDone   = 3'd5
    } ram_ctrl_state_e;

    // A store that touches some but not all lanes needs the old word first.
    function automatic logic is_partial(input logic [3:0] sel);
        is_partial = (sel != SelAll) && (sel != SelNone);
    endfunction

endpackage

// File: rtl/ram1_ctrl_byte_merge.sv
// Four-lane byte merge: each lane takes the new byte when its select is set,
// otherwise keeps the old byte. Purely combinational.
module ram1_ctrl_byte_merge
    import ram1_ctrl_pkg::*;
(
    input  logic [3:0]         sel_i,
    input  logic [DataBus-1:0] new_i,
    input  logic [DataBus-1:0] old_i,
    output logic [DataBus-1:0] merged_o
);

    // Lane-by-lane select; sel_i[n] owns bits [8n+7:8n].
    always_comb begin
        merged_o = ZeroWord;
        for (int i = 0; i < 4; i++) begin
            if (sel_i[i]) begin
                merged_o[8*i +: 8] = new_i[8*i +: 8];
            end else begin
                merged_o[8*i +: 8] = old_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/ram1_ctrl.sv
// Memory-side controller for the ram1 data port: turns one byte-addressed CPU
// request into a word-addressed RAM sequence, using read-modify-write for partial stores.
module ram1_ctrl
    import ram1_ctrl_pkg::*;
#(
    parameter int RAM_AW  = 12,
    parameter int RD_WAIT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_ce,
    input  logic                   cpu_we,
    input  logic [3:0]             cpu_sel,
    input  logic [DataAddrBus-1:0] cpu_addr,
    input  logic [DataBus-1:0]     cpu_data_i,
    output logic [DataBus-1:0]     cpu_data_o,
    output logic                   stallreq,
    output logic                   mem_ce,
    output logic                   mem_re,
    output logic                   mem_we,
    output logic [DataAddrBus-1:0] mem_addr,
    output logic [DataBus-1:0]     mem_data_o,
    input  logic [DataBus-1:0]     mem_data_i
);

    localparam int CntW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(RD_WAIT - 1);

    ram_ctrl_state_e        state_q;
    logic [DataAddrBus-1:0] addr_q;
    logic                   we_q;
    logic [3:0]             sel_q;
    logic [DataBus-1:0]     data_q;
    logic [DataBus-1:0]     rdata_q;
    logic [CntW-1:0]        cnt_q;
    logic                   mem_ce_q;
    logic                   mem_re_q;
    logic                   mem_we_q;
    logic [DataAddrBus-1:0] mem_addr_q;
    logic [DataBus-1:0]     mem_data_q;
    logic [DataBus-1:0]     cpu_data_q;

    logic [DataAddrBus-1:0] req_idx_s;
    logic [DataBus-1:0]     merged_s;
    logic                   unused_addr_s;

    // Word index the RAM decodes; bits above RAM_AW are forced to zero.
    function automatic logic [DataAddrBus-1:0] word_idx(input logic [DataAddrBus-1:0] a);
        word_idx = ZeroWord;
        word_idx[RAM_AW-1:0] = a[RAM_AW+1:2];
    endfunction

    assign req_idx_s     = word_idx(cpu_addr);
    assign unused_addr_s = ^{cpu_addr[DataAddrBus-1:RAM_AW+2], cpu_addr[1:0]};

    ram1_ctrl_byte_merge u_merge (
        .sel_i    (sel_q),
        .new_i    (data_q),
        .old_i    (rdata_q),
        .merged_o (merged_s)
    );

    // Combinational so the pipeline already stalls in the cycle the request appears.
    assign stallreq = ((state_q == RamCtrlIdle) && cpu_ce) ||
                      ((state_q != RamCtrlIdle) && (state_q != RamCtrlDone));

    assign mem_ce     = mem_ce_q;
    assign mem_re     = mem_re_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data_o = mem_data_q;
    assign cpu_data_o = cpu_data_q;

    // Transaction sequencer; RAM-facing outputs are set on entry to each state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RamCtrlIdle;
            addr_q     <= ZeroWord;
            we_q       <= 1'b0;
            sel_q      <= SelNone;
            data_q     <= ZeroWord;
            rdata_q    <= ZeroWord;
            cnt_q      <= {CntW{1'b0}};
            mem_ce_q   <= RamChipDisable;
            mem_re_q   <= ReadDisable;
            mem_we_q   <= WriteDisable;
            mem_addr_q <= ZeroWord;
            mem_data_q <= ZeroWord;
            cpu_data_q <= ZeroWord;
        end else begin
            case (state_q)
                RamCtrlIdle: begin
                    if (cpu_ce) begin
                        addr_q <= req_idx_s;
                        we_q   <= cpu_we;
                        sel_q  <= cpu_sel;
                        data_q <= cpu_data_i;
                        cnt_q  <= {CntW{1'b0}};
                        if (!cpu_we || is_partial(cpu_sel)) begin
                            state_q    <= RamCtrlRd;
                            mem_ce_q   <= RamChipEnable;
                            mem_re_q   <= ReadEnable;
                            mem_addr_q <= req_idx_s;
                        end else if (cpu_sel == SelAll) begin
                            state_q    <= RamCtrlWr;
                            mem_ce_q   <= RamChipEnable;
                            mem_we_q   <= WriteEnable;
                            mem_addr_q <= req_idx_s;
                            mem_data_q <= cpu_data_i;
                        end else begin
                            state_q <= RamCtrlDone;
                        end
                    end else begin
                        state_q <= RamCtrlIdle;
                    end
                end
                RamCtrlRd: begin
                    if (cnt_q == CntLast) begin
                        rdata_q  <= mem_data_i;
                        mem_re_q <= ReadDisable;
                        if (we_q) begin
                            state_q <= RamCtrlMerge;
                        end else begin
                            state_q    <= RamCtrlDone;
                            cpu_data_q <= mem_data_i;
                            mem_ce_q   <= RamChipDisable;
                            mem_addr_q <= ZeroWord;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1'b1);
                    end
                end
                RamCtrlMerge: begin
                    state_q    <= RamCtrlWr;
                    mem_we_q   <= WriteEnable;
                    mem_addr_q <= addr_q;
                    mem_data_q <= merged_s;
                end
                RamCtrlWr: begin
                    state_q  <= RamCtrlWrHold;
                    mem_we_q <= WriteDisable;
                end
                RamCtrlWrHold: begin
                    state_q    <= RamCtrlDone;
                    mem_ce_q   <= RamChipDisable;
                    mem_addr_q <= ZeroWord;
                    mem_data_q <= ZeroWord;
                end
                RamCtrlDone: begin
                    state_q <= RamCtrlIdle;
                end
                default: begin
                    state_q    <= RamCtrlIdle;
                    mem_ce_q   <= RamChipDisable;
                    mem_re_q   <= ReadDisable;
                    mem_we_q   <= WriteDisable;
                    mem_addr_q <= ZeroWord;
                    mem_data_q <= ZeroWord;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram1_ctrl.sv
// Bench for ram1_ctrl: a transaction-level model predicts every cycle's outputs,
// driven by a directed table followed by randomized requests with junk mid-transaction.
module tb_ram1_ctrl;

    localparam int RAM_AW  = 12;
    localparam int RD_WAIT = 1;
    localparam int ND      = 11;

    logic        clk, rst, cpu_ce, cpu_we;
    logic [3:0]  cpu_sel;
    logic [31:0] cpu_addr, cpu_data_i, cpu_data_o;
    logic        stallreq, mem_ce, mem_re, mem_we;
    logic [31:0] mem_addr, mem_data_o, mem_data_i;

    logic [31:0] ram [0:4095];
    logic [31:0] mdl [0:4095];
    int total, bad;

    typedef struct {
        bit          stall, ce, re, we;
        bit          chk_ce, chk_addr, chk_data, wr, done, ld_done;
        logic [31:0] addr, data, ld_val;
    } rec_t;

    typedef struct {
        bit          we;
        logic [3:0]  sel;
        logic [31:0] addr, data;
        int          st, re, wn, ce;
        bit          chk_rd;
        logic [31:0] rd;
        bit          abort;
    } dreq_t;

    rec_t  q[$];
    dreq_t dt [ND];

    ram1_ctrl #(.RAM_AW(RAM_AW), .RD_WAIT(RD_WAIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_ce     (cpu_ce),
        .cpu_we     (cpu_we),
        .cpu_sel    (cpu_sel),
        .cpu_addr   (cpu_addr),
        .cpu_data_i (cpu_data_i),
        .cpu_data_o (cpu_data_o),
        .stallreq   (stallreq),
        .mem_ce     (mem_ce),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data_o (mem_data_o),
        .mem_data_i (mem_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 16) return 32'hDEAD_BEEF;
        if (i == 18) return 32'h0BAD_F00D;
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // RAM without byte enables: combinational read while re is high, write on the clock edge.
    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_ce && mem_we) ram[mem_addr[11:0]] = mem_data_o;
        end
    end
    assign mem_data_i = (mem_ce && mem_re) ? ram[mem_addr[11:0]] : 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic rec_t blank();
        rec_t r;
        r.stall = 1'b0; r.ce = 1'b0; r.re = 1'b0; r.we = 1'b0;
        r.chk_ce = 1'b1; r.chk_addr = 1'b0; r.chk_data = 1'b0;
        r.wr = 1'b0; r.done = 1'b0; r.ld_done = 1'b0;
        r.addr = 32'h0; r.data = 32'h0; r.ld_val = 32'h0;
        return r;
    endfunction

    // Expand one accepted request into the per-cycle output sequence that must follow it.
    task automatic accept(input logic we, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] a, old, mask, nw;
        bit partial;
        rec_t r;
        a = {20'h0, addr[13:2]};
        old = mdl[a[11:0]];
        mask = 32'h0;
        for (int i = 0; i < 4; i++) if (sel[i]) mask = mask | (32'hFF << (8 * i));
        nw = (old & ~mask) | (data & mask);
        partial = (sel != 4'hF) && (sel != 4'h0);
        if (!we || partial) begin
            for (int k = 0; k < RD_WAIT; k++) begin
                r = blank(); r.stall = 1'b1; r.ce = 1'b1; r.re = 1'b1;
                r.chk_addr = 1'b1; r.addr = a;
                q.push_back(r);
            end
        end
        if (we && partial) begin
            r = blank(); r.stall = 1'b1; r.chk_ce = 1'b0;
            q.push_back(r);
        end
        if (we && sel != 4'h0) begin
            r = blank(); r.stall = 1'b1; r.ce = 1'b1; r.we = 1'b1; r.wr = 1'b1;
            r.chk_addr = 1'b1; r.chk_data = 1'b1; r.addr = a; r.data = nw;
            q.push_back(r);
            r.we = 1'b0; r.wr = 1'b0;
            q.push_back(r);
        end
        r = blank(); r.done = 1'b1;
        if (!we) begin
            r.ld_done = 1'b1; r.ld_val = old;
        end
        q.push_back(r);
    endtask

    initial begin
        rec_t        r;
        logic [31:0] exp_rd;
        int          di, cur_dir, rst_hold, n_st, n_re, n_we, n_ce;
        bit          abort_armed;

        dt[0]  = '{1'b0, 4'hF, 32'h40, 32'h0,        2, 1, 0,  1, 1'b1, 32'hDEAD_BEEF, 1'b0};
        dt[1]  = '{1'b1, 4'hF, 32'h44, 32'h1234_5678, 3, 0, 1,  2, 1'b0, 32'h0,         1'b0};
        dt[2]  = '{1'b0, 4'hF, 32'h44, 32'h0,        2, 1, 0,  1, 1'b1, 32'h1234_5678, 1'b0};
        dt[3]  = '{1'b1, 4'h4, 32'h45, 32'h00AB_0000, 5, 1, 1, -1, 1'b0, 32'h0,         1'b0};
        dt[4]  = '{1'b0, 4'hF, 32'h44, 32'h0,        2, 1, 0,  1, 1'b1, 32'h12AB_5678, 1'b0};
        dt[5]  = '{1'b1, 4'h3, 32'h44, 32'h0000_CAFE, 5, 1, 1, -1, 1'b0, 32'h0,         1'b0};
        dt[6]  = '{1'b0, 4'hF, 32'h44, 32'h0,        2, 1, 0,  1, 1'b1, 32'h12AB_CAFE, 1'b0};
        dt[7]  = '{1'b1, 4'h0, 32'h44, 32'hFFFF_FFFF, 1, 0, 0,  0, 1'b0, 32'h0,         1'b0};
        dt[8]  = '{1'b0, 4'hF, 32'h44, 32'h0,        2, 1, 0,  1, 1'b1, 32'h12AB_CAFE, 1'b0};
        dt[9]  = '{1'b1, 4'hF, 32'h48, 32'hA5A5_A5A5, 3, 0, 1,  2, 1'b0, 32'h0,         1'b1};
        dt[10] = '{1'b0, 4'hF, 32'h48, 32'h0,        2, 1, 0,  1, 1'b1, 32'h0BAD_F00D, 1'b0};

        for (int i = 0; i < 4096; i++) mdl[i] = init_word(i);
        total = 0; bad = 0; exp_rd = 32'h0;
        di = 0; cur_dir = -1; rst_hold = 3; abort_armed = 1'b0;
        n_st = 0; n_re = 0; n_we = 0; n_ce = 0;
        cpu_ce = 1'b1; cpu_we = 1'b0; cpu_sel = 4'hF; cpu_addr = 32'h40; cpu_data_i = 32'h0;
        rst = 1'b1;
        #1 rst = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            if (rst_hold > 0) begin
                rst = 1'b0;
                rst_hold--;
            end else begin
                rst = 1'b1;
                if (q.size() == 0) begin
                    if (di < ND) begin
                        cur_dir = di;
                        cpu_ce = 1'b1; cpu_we = dt[di].we; cpu_sel = dt[di].sel;
                        cpu_addr = dt[di].addr; cpu_data_i = dt[di].data;
                        abort_armed = dt[di].abort;
                        di++;
                    end else begin
                        cur_dir = -1;
                        cpu_ce = ($urandom_range(0, 3) != 0);
                        cpu_we = 1'($urandom());
                        case ($urandom_range(0, 7))
                            0, 1:    cpu_sel = 4'hF;
                            2:       cpu_sel = 4'h0;
                            default: cpu_sel = 4'($urandom());
                        endcase
                        cpu_addr = $urandom();
                        if ($urandom_range(0, 1) == 1) cpu_addr[13:2] = 12'($urandom_range(0, 15));
                        cpu_data_i = $urandom();
                    end
                end else if (cur_dir < 0) begin
                    cpu_ce = 1'($urandom()); cpu_we = 1'($urandom()); cpu_sel = 4'($urandom());
                    cpu_addr = $urandom(); cpu_data_i = $urandom();
                end
                // Reset in the middle of the write cycle must drop we without a clock edge.
                if (abort_armed && q.size() > 0 && q[0].wr) begin
                    chk("abort_we_before", mem_we, 1'b1);
                    #2 rst = 1'b0;
                    #1;
                    chk("abort_we_async", mem_we, 1'b0);
                    chk("abort_ce_async", mem_ce, 1'b0);
                    abort_armed = 1'b0;
                    rst_hold = 2;
                end
            end

            @(negedge clk);
            if (!rst) begin
                q.delete();
                exp_rd = 32'h0;
                chk("rst_stall", stallreq, cpu_ce);
                chk("rst_ce", mem_ce, 1'b0);
                chk("rst_re", mem_re, 1'b0);
                chk("rst_we", mem_we, 1'b0);
                chk("rst_addr", mem_addr, 32'h0);
                chk("rst_wdata", mem_data_o, 32'h0);
                chk("rst_rdata", cpu_data_o, 32'h0);
            end else if (q.size() == 0) begin
                chk("idle_stall", stallreq, cpu_ce);
                chk("idle_ce", mem_ce, 1'b0);
                chk("idle_re", mem_re, 1'b0);
                chk("idle_we", mem_we, 1'b0);
                chk("idle_rdata", cpu_data_o, exp_rd);
                if (cpu_ce) begin
                    accept(cpu_we, cpu_sel, cpu_addr, cpu_data_i);
                    n_st = int'(stallreq); n_re = int'(mem_re);
                    n_we = int'(mem_we);   n_ce = int'(mem_ce);
                end
            end else begin
                r = q.pop_front();
                if (r.wr) mdl[r.addr[11:0]] = r.data;
                if (r.ld_done) exp_rd = r.ld_val;
                chk("stall", stallreq, r.stall);
                chk("re", mem_re, r.re);
                chk("we", mem_we, r.we);
                chk("re_we_excl", mem_re & mem_we, 1'b0);
                chk("rdata", cpu_data_o, exp_rd);
                if (r.chk_ce) chk("ce", mem_ce, r.ce);
                if (r.chk_addr) chk("addr", mem_addr, r.addr);
                if (r.chk_data) chk("wdata", mem_data_o, r.data);
                n_st += int'(stallreq); n_re += int'(mem_re);
                n_we += int'(mem_we);   n_ce += int'(mem_ce);
                if (r.done && cur_dir >= 0) begin
                    chk("dir_stall_cycles", n_st, dt[cur_dir].st);
                    chk("dir_re_cycles", n_re, dt[cur_dir].re);
                    chk("dir_we_cycles", n_we, dt[cur_dir].wn);
                    if (dt[cur_dir].ce >= 0) chk("dir_ce_cycles", n_ce, dt[cur_dir].ce);
                    if (dt[cur_dir].chk_rd) chk("dir_load_data", cpu_data_o, dt[cur_dir].rd);
                end
            end
        end

        chk("directed_all_issued", di, ND);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
